// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the core EXECUTE stage and the multiply/divide unit.
interface alu_muldiv_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (output in_valid, op, rs1_val, rs2_val, flush, out_ready,
                    input  in_ready, out_valid, result, busy);
    modport slave  (input  in_valid, op, rs1_val, rs2_val, flush, out_ready,
                    output in_ready, out_valid, result, busy);
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply (or single-cycle),
// restoring radix-2 divide on magnitudes, RISC-V divide special cases, flush.
module alu_muldiv #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_r;
    logic            neg_p, neg_r;
    logic [XLEN-1:0] b_reg, res_q, res_nxt;
    logic [W2-1:0]   acc, mcand, acc_nxt;

    logic            accept, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, last;
    logic [XLEN-1:0] mag_a, mag_b, spec_res, q_fin, r_fin;
    logic [W2-1:0]   fast_p, fast_sp, fin_p;
    logic [XLEN:0]   trial;

    assign accept = bus.in_valid && bus.in_ready;

    // Accept-time decode: signedness, magnitudes and the no-iteration divide cases
    always_comb begin
        sgn_a    = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
        sgn_b    = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
        a_neg    = sgn_a && bus.rs1_val[XLEN-1];
        b_neg    = sgn_b && bus.rs2_val[XLEN-1];
        mag_a    = a_neg ? -bus.rs1_val : bus.rs1_val;
        mag_b    = b_neg ? -bus.rs2_val : bus.rs2_val;
        div_zero = (bus.rs2_val == '0);
        div_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                   (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
        if (div_zero) spec_res = bus.op[1] ? bus.rs1_val : '1;
        else          spec_res = bus.op[1] ? '0 : bus.rs1_val;
        fast_p   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        fast_sp  = (a_neg ^ b_neg) ? -fast_p : fast_p;
    end

    // One iteration step; acc holds the product, or {remainder, dividend/quotient}
    always_comb begin
        trial = acc[W2-1:XLEN-1] - {1'b0, b_reg};
        if (state == MUL)  acc_nxt = b_reg[0] ? acc + mcand : acc;
        else if (trial[XLEN]) acc_nxt = {acc[W2-2:0], 1'b0};
        else               acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        last  = (cnt == CW'(XLEN-1));
        fin_p = neg_p ? -acc_nxt : acc_nxt;
        q_fin = neg_p ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        r_fin = neg_r ? -acc_nxt[W2-1:XLEN] : acc_nxt[W2-1:XLEN];
    end

    always_comb begin
        case (state)
            IDLE:    res_nxt = bus.op[2] ? spec_res :
                               ((bus.op == 3'd0) ? fast_sp[XLEN-1:0] : fast_sp[W2-1:XLEN]);
            MUL:     res_nxt = (op_r == 3'd0) ? fin_p[XLEN-1:0] : fin_p[W2-1:XLEN];
            DIV:     res_nxt = op_r[1] ? r_fin : q_fin;
            default: res_nxt = res_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) state_nxt = IDLE;
        else begin
            case (state)
                IDLE: if (accept) begin
                    if (bus.op[2]) state_nxt = (div_zero || div_ovf) ? DONE : DIV;
                    else           state_nxt = FAST_MUL ? DONE : MUL;
                end
                MUL, DIV: if (last) state_nxt = DONE;
                DONE: if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.out_valid = (state == DONE);
        bus.busy      = (state == MUL) || (state == DIV);
        bus.result    = res_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            res_q <= '0;
            op_r  <= '0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
            b_reg <= '0;
            acc   <= '0;
            mcand <= '0;
        end else begin
            if (accept) begin
                cnt   <= '0;
                op_r  <= bus.op;
                neg_p <= a_neg ^ b_neg;
                neg_r <= a_neg;
                b_reg <= mag_b;
                mcand <= {{XLEN{1'b0}}, mag_a};
                acc   <= bus.op[2] ? {{XLEN{1'b0}}, mag_a} : '0;
            end else if ((state == MUL) || (state == DIV)) begin
                cnt   <= cnt + CW'(1);
                acc   <= acc_nxt;
                mcand <= mcand << 1;
                if (state == MUL) b_reg <= b_reg >> 1;
            end
            // state_nxt already folds in flush, so an aborted op never lands here
            if ((state != DONE) && (state_nxt == DONE)) res_q <= res_nxt;
        end
    end
endmodule
